// File: rtl/dac_channel_sequencer.sv
// Round-robin writer that time-multiplexes NUM_CH channel words onto one shared
// parallel DAC bus. Each slot runs setup, strobe and hold phases. Optionally, a
// channel whose word has not changed since its last write is skipped.
//
// state  | meaning
// IDLE   | no slot in progress; a decision is made every cycle while enabled
// SETUP  | select/data driven, strobe low
// STROBE | write_signal high
// HOLD   | select/data held after strobe; the last cycle is the next decision
module dac_channel_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int SEL_W     = 2,
    parameter int SETUP_CYC = 4,
    parameter int WR_CYC    = 8,
    parameter int HOLD_CYC  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     only_changed,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     write_signal,
    output logic [SEL_W-1:0]         gest_select,
    output logic [DATA_W-1:0]        gest_out,
    output logic                     frame_done
);

    localparam int MAX_SW  = (SETUP_CYC > WR_CYC) ? SETUP_CYC : WR_CYC;
    localparam int MAX_CYC = (MAX_SW > HOLD_CYC) ? MAX_SW : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [SEL_W-1:0]    last_ch_q, last_ch_d;
    logic [DATA_W-1:0]   shadow_q [NUM_CH];
    logic [DATA_W-1:0]   shadow_d [NUM_CH];
    logic [NUM_CH-1:0]   valid_q, valid_d;

    logic [NUM_CH-1:0]   elig;
    logic                any_elig;
    logic                hi_found;
    logic                wrap;
    logic [SEL_W-1:0]    pick_lo, pick_hi, pick;
    logic [DATA_W-1:0]   data_lo, data_hi, pick_data;
    logic                decide;

    assign gest_select = sel_q;
    assign gest_out    = out_q;

    // Eligibility and round-robin pick; descending scan so the lowest index wins.
    always_comb begin
        elig     = '0;
        pick_lo  = '0;
        pick_hi  = '0;
        data_lo  = '0;
        data_hi  = '0;
        hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            elig[i] = ch_enable[i] &
                      (~only_changed | ~valid_q[i] |
                       (ch_data[i*DATA_W +: DATA_W] != shadow_q[i]));
            if (elig[i]) begin
                pick_lo = SEL_W'(i);
                data_lo = ch_data[i*DATA_W +: DATA_W];
                if (i > int'(last_ch_q)) begin
                    hi_found = 1'b1;
                    pick_hi  = SEL_W'(i);
                    data_hi  = ch_data[i*DATA_W +: DATA_W];
                end
            end
        end
        any_elig  = |elig;
        wrap      = ~hi_found;
        pick      = hi_found ? pick_hi : pick_lo;
        pick_data = hi_found ? data_hi : data_lo;
    end

    // Slot sequencing, shadow capture and slot-start decision.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        out_d        = out_q;
        last_ch_d    = last_ch_q;
        shadow_d     = shadow_q;
        valid_d      = valid_q;
        write_signal = 1'b0;
        frame_done   = 1'b0;
        decide       = 1'b0;

        case (state_q)
            IDLE: decide = 1'b1;
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = WR_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                write_signal = 1'b1;
                if (cnt_q == WR_LD) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (SEL_W'(i) == last_ch_q) begin
                            shadow_d[i] = out_q;
                            valid_d[i]  = 1'b1;
                        end
                    end
                end
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    decide     = 1'b1;
                    frame_done = ~any_elig | wrap;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (decide) begin
            if (enable && any_elig) begin
                state_d   = SETUP;
                cnt_d     = SETUP_LD;
                sel_d     = pick;
                out_d     = pick_data;
                last_ch_d = pick;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State register; reset aborts any slot in progress and invalidates shadows.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            out_q     <= '0;
            last_ch_q <= SEL_W'(NUM_CH - 1);
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            out_q     <= out_d;
            last_ch_q <= last_ch_d;
            valid_q   <= valid_d;
        end
    end

    // Shadow words carry no reset; their valid bits gate their use.
    always_ff @(posedge clock) begin
        shadow_q <= shadow_d;
    end

endmodule
